// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + 32'(idx) * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into little-endian words; the first byte ends up in word_o[7:0].
module word_assembler
    import loader_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [7:0]              byte_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    word_valid_o
);

    localparam int CW = $clog2(WORD_BYTES);

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [8*WORD_BYTES-1:0]   sr_q, sr_d;

    // The completed word is presented combinationally alongside the last byte.
    assign word_o       = {byte_i, sr_q[8*WORD_BYTES-1:8]};
    assign word_valid_o = push_i && (cnt_q == CW'(WORD_BYTES - 1));

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear_i || word_valid_o) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (push_i) begin
            cnt_d = cnt_q + CW'(1);
            sr_d  = word_o;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed image into BRAM over the native memory interface, holding the CPU until done.
//   state  | meaning
//   CNT_LO | waiting for low byte of word count
//   CNT_HI | waiting for high byte of word count
//   DATA   | assembling the next data word
//   WRITE  | memory request outstanding
//   DONE   | one-cycle completion, CPU released
//   ERROR  | oversized image, locked until reset
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        mem_valid_o,
    output logic        mem_instr_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    output logic        cpu_hold_o,
    output logic        load_done_o,
    output logic        load_error_o
);

    loader_state_t           state_q, state_d;
    logic [8*HDR_BYTES-1:0]  count_q, count_d;
    logic [15:0]             idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    load_done_q, load_done_d;
    logic                    load_error_q, load_error_d;

    logic                    accept;
    logic                    asm_push;
    logic                    asm_clear;
    logic [31:0]             asm_word;
    logic                    asm_word_valid;
    logic [8*HDR_BYTES-1:0]  hdr_n;
    logic                    unused_rdata;

    assign accept       = rx_valid_i && rx_ready_q;
    assign asm_push     = accept && (state_q == DATA);
    assign hdr_n        = {rx_data_i, count_q[8*HDR_BYTES-1:8]};
    assign unused_rdata = ^mem_rdata_i;

    word_assembler u_asm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (asm_clear),
        .push_i       (asm_push),
        .byte_i       (rx_data_i),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_valid_d  = mem_valid_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        asm_clear    = 1'b0;

        case (state_q)
            CNT_LO: if (accept) begin
                count_d    = hdr_n;
                cpu_hold_d = 1'b1;
                state_d    = CNT_HI;
            end
            CNT_HI: if (accept) begin
                count_d   = hdr_n;
                asm_clear = 1'b1;
                if (hdr_n == '0) begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                    cpu_hold_d  = 1'b0;
                end else if (hdr_n > MAX_WORDS) begin
                    state_d      = ERROR;
                    load_error_d = 1'b1;
                end else begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: if (asm_word_valid) begin
                addr_d      = word_addr(BASE_ADDR, idx_q);
                wdata_d     = asm_word;
                mem_valid_d = 1'b1;
                state_d     = WRITE;
            end
            WRITE: if (mem_ready_i) begin
                mem_valid_d = 1'b0;
                idx_d       = idx_q + 16'd1;
                // 17-bit compare so a full-range index cannot wrap past the count
                if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) begin
                    state_d = DATA;
                end else begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                    cpu_hold_d  = 1'b0;
                end
            end
            DONE:    state_d = CNT_LO;
            ERROR:   state_d = ERROR;
            default: state_d = CNT_LO;
        endcase

        rx_ready_d = (state_d == CNT_LO) || (state_d == CNT_HI) || (state_d == DATA);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= CNT_LO;
            count_q      <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            rx_ready_q   <= 1'b1;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_valid_q  <= mem_valid_d;
            rx_ready_q   <= rx_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_instr_o  = 1'b0;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wstrb_o  = {4{mem_valid_q}};
    assign cpu_hold_o   = cpu_hold_q;
    assign load_done_o  = load_done_q;
    assign load_error_o = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed byte streams, BRAM responder, write monitor.
module tb_program_loader;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid1, rx_valid2;
    logic        rx_ready1, rx_ready2;
    logic        mem_valid1, mem_valid2;
    logic        mem_instr1, mem_instr2;
    logic        mem_ready1, mem_ready2;
    logic [31:0] mem_addr1, mem_addr2;
    logic [31:0] mem_wdata1, mem_wdata2;
    logic [3:0]  mem_wstrb1, mem_wstrb2;
    logic        cpu_hold1, cpu_hold2;
    logic        load_done1, load_done2;
    logic        load_error1, load_error2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 0;
    int          cnt1, cnt2;
    int          done_cnt1 = 0, done_cnt2 = 0;
    int          mv_cnt1 = 0;
    logic        pv1 = 1'b0, pv2 = 1'b0;
    logic [31:0] pa1, pd1, pa2, pd2;
    logic [31:0] bram [16];
    wr_t         expq [$];
    logic [7:0]  bq [$];

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(16'd1024)) dut1 (
        .clk_i(clk), .reset_i(reset), .rx_valid_i(rx_valid1), .rx_data_i(rx_data),
        .rx_ready_o(rx_ready1), .mem_valid_o(mem_valid1), .mem_instr_o(mem_instr1),
        .mem_ready_i(mem_ready1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
        .mem_wstrb_o(mem_wstrb1), .mem_rdata_i(32'h0), .cpu_hold_o(cpu_hold1),
        .load_done_o(load_done1), .load_error_o(load_error1)
    );

    program_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(16'd1024)) dut2 (
        .clk_i(clk), .reset_i(reset), .rx_valid_i(rx_valid2), .rx_data_i(rx_data),
        .rx_ready_o(rx_ready2), .mem_valid_o(mem_valid2), .mem_instr_o(mem_instr2),
        .mem_ready_i(mem_ready2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
        .mem_wstrb_o(mem_wstrb2), .mem_rdata_i(32'h0), .cpu_hold_o(cpu_hold2),
        .load_done_o(load_done2), .load_error_o(load_error2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // BRAM model: completes a request lat+1 cycles after mem_valid is first seen
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready1 <= 1'b0;
            mem_ready2 <= 1'b0;
            cnt1       <= 0;
            cnt2       <= 0;
        end else begin
            mem_ready1 <= 1'b0;
            mem_ready2 <= 1'b0;
            if (mem_valid1 && !mem_ready1) begin
                if (cnt1 >= lat) begin mem_ready1 <= 1'b1; cnt1 <= 0; end
                else cnt1 <= cnt1 + 1;
            end
            if (mem_valid2 && !mem_ready2) begin
                if (cnt2 >= lat) begin mem_ready2 <= 1'b1; cnt2 <= 0; end
                else cnt2 <= cnt2 + 1;
            end
            if (mem_valid1 && mem_ready1) bram[mem_addr1[5:2]] <= mem_wdata1;
            if (mem_valid2 && mem_ready2) bram[mem_addr2[5:2]] <= mem_wdata2;
        end
    end

    task automatic score_write(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none", a, d);
        end else begin
            e = expq.pop_front();
            check("wr_addr", a, e.a);
            check("wr_data", d, e.d);
        end
    endtask

    // Monitor: protocol stability checks and scoreboard pops on each completed write
    always @(negedge clk) begin
        if (!reset) begin
            if (load_done1) done_cnt1 <= done_cnt1 + 1;
            if (load_done2) done_cnt2 <= done_cnt2 + 1;
            if (mem_valid1) mv_cnt1 <= mv_cnt1 + 1;
            if (mem_valid1) begin
                check("wstrb1", 32'(mem_wstrb1), 32'hF);
                check("rx_ready_in_write1", 32'(rx_ready1), 32'h0);
                if (pv1) begin
                    check("addr_stable1", mem_addr1, pa1);
                    check("wdata_stable1", mem_wdata1, pd1);
                end
            end
            if (mem_valid2) begin
                check("rx_ready_in_write2", 32'(rx_ready2), 32'h0);
                if (pv2) check("addr_stable2", mem_addr2, pa2);
            end
            if (mem_valid1 && mem_ready1) score_write(mem_addr1, mem_wdata1);
            if (mem_valid2 && mem_ready2) score_write(mem_addr2, mem_wdata2);
            pv1 <= mem_valid1 && !mem_ready1;
            pa1 <= mem_addr1;
            pd1 <= mem_wdata1;
            pv2 <= mem_valid2 && !mem_ready2;
            pa2 <= mem_addr2;
            pd2 <= mem_wdata2;
        end
    end

    task automatic send_byte(input bit sel, input logic [7:0] b);
        int n = 0;
        rx_data = b;
        if (sel) rx_valid2 = 1'b1; else rx_valid1 = 1'b1;
        while (((sel ? rx_ready2 : rx_ready1) !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 32'(sel ? rx_ready2 : rx_ready1), 32'h1);
        @(negedge clk);
        rx_valid1 = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic send_bytes(input bit sel, input int gap_max);
        foreach (bq[i]) begin
            send_byte(sel, bq[i]);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        bq.delete();
    endtask

    task automatic wait_done(input bit sel, input int d0);
        int n = 0;
        while (((sel ? done_cnt2 : done_cnt1) == d0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(sel ? "done_pulse2" : "done_pulse1", 32'((sel ? done_cnt2 : done_cnt1) - d0), 32'h1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready1),   32'h1);
        check({tag, "_mem_valid"},  32'(mem_valid1),  32'h0);
        check({tag, "_mem_wstrb"},  32'(mem_wstrb1),  32'h0);
        check({tag, "_mem_addr"},   mem_addr1,        32'h0);
        check({tag, "_mem_wdata"},  mem_wdata1,       32'h0);
        check({tag, "_cpu_hold"},   32'(cpu_hold1),   32'h1);
        check({tag, "_load_done"},  32'(load_done1),  32'h0);
        check({tag, "_load_error"}, 32'(load_error1), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, m0;
        reset     = 1'b1;
        rx_valid1 = 1'b0;
        rx_valid2 = 1'b0;
        rx_data   = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        check("mem_instr", 32'(mem_instr1), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word image, single-cycle BRAM
        lat = 0;
        expq.push_back('{32'h0, 32'h02A0_0513});
        expq.push_back('{32'h4, 32'h0000_02B3});
        bq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h02, 8'hB3, 8'h02, 8'h00, 8'h00};
        d0 = done_cnt1;
        send_bytes(0, 0);
        wait_done(0, d0);
        check("t1_cpu_hold", 32'(cpu_hold1), 32'h0);
        check("t1_bram0", bram[0], 32'h02A0_0513);
        check("t1_bram1", bram[1], 32'h0000_02B3);
        check("t1_queue_empty", 32'(expq.size()), 32'h0);

        // Empty image: done two cycles after first header byte, no traffic
        m0 = mv_cnt1;
        send_byte(0, 8'h00);
        check("t2_cpu_hold_raised", 32'(cpu_hold1), 32'h1);
        check("t2_done_early", 32'(load_done1), 32'h0);
        send_byte(0, 8'h00);
        check("t2_load_done", 32'(load_done1), 32'h1);
        check("t2_cpu_hold_low", 32'(cpu_hold1), 32'h0);
        @(negedge clk);
        check("t2_load_done_drop", 32'(load_done1), 32'h0);
        check("t2_no_mem_valid", 32'(mv_cnt1 - m0), 32'h0);

        // Three words, random rx gaps, slow BRAM
        lat = 3;
        expq.push_back('{32'h0, 32'h1122_3344});
        expq.push_back('{32'h4, 32'hDEAD_BEEF});
        expq.push_back('{32'h8, 32'h0000_0001});
        bq = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h01, 8'h00, 8'h00, 8'h00};
        d0 = done_cnt1;
        send_bytes(0, 3);
        wait_done(0, d0);
        check("t3_bram0", bram[0], 32'h1122_3344);
        check("t3_bram1", bram[1], 32'hDEAD_BEEF);
        check("t3_bram2", bram[2], 32'h0000_0001);
        check("t3_queue_empty", 32'(expq.size()), 32'h0);

        // Reset while word 1 of 3 is outstanding
        lat = 6;
        expq.push_back('{32'h0, 32'h7654_3210});
        bq = '{8'h03, 8'h00, 8'h10, 8'h32, 8'h54, 8'h76, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        send_bytes(0, 0);
        check("t4_mem_valid", 32'(mem_valid1), 32'h1);
        check("t4_mem_addr", mem_addr1, 32'h4);
        check("t4_mem_wdata", mem_wdata1, 32'h89AB_CDEF);
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t4_queue_empty", 32'(expq.size()), 32'h0);
        lat = 0;
        expq.push_back('{32'h0, 32'hCAFE_F00D});
        bq = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        d0 = done_cnt1;
        send_bytes(0, 0);
        wait_done(0, d0);
        check("t4_bram0", bram[0], 32'hCAFE_F00D);
        check("t4_bram1_untouched", bram[1], 32'hDEAD_BEEF);

        // Oversized header locks the loader until reset
        m0 = mv_cnt1;
        bq = '{8'h01, 8'h04};
        send_bytes(0, 0);
        check("t5_load_error", 32'(load_error1), 32'h1);
        check("t5_rx_ready", 32'(rx_ready1), 32'h0);
        check("t5_cpu_hold", 32'(cpu_hold1), 32'h1);
        rx_data   = 8'h55;
        rx_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_accept", 32'(rx_ready1), 32'h0);
        end
        rx_valid1 = 1'b0;
        check("t5_error_sticky", 32'(load_error1), 32'h1);
        check("t5_no_mem_valid", 32'(mv_cnt1 - m0), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_error_cleared", 32'(load_error1), 32'h0);
        check("t5_rx_ready_back", 32'(rx_ready1), 32'h1);

        // Address wrap from top of memory
        lat = 1;
        expq.push_back('{32'hFFFF_FFFC, 32'hAABB_CCDD});
        expq.push_back('{32'h0000_0000, 32'h1234_5678});
        bq = '{8'h02, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h78, 8'h56, 8'h34, 8'h12};
        d0 = done_cnt2;
        send_bytes(1, 0);
        wait_done(1, d0);
        check("t6_bram15", bram[15], 32'hAABB_CCDD);
        check("t6_bram0", bram[0], 32'h1234_5678);
        check("t6_cpu_hold", 32'(cpu_hold2), 32'h0);
        check("t6_queue_empty", 32'(expq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
